usb_status_tx: RTL and testbench
================================

// Module: usb_status_tx
// PURPOSE
//  FPGA->PC key-and-status packetizer for the FX3 IN endpoint 0x86 (fifo_data_rx, faddr 0b01).
//  On request, snapshots GBA key state plus status words and streams a fixed 32-byte frame.
//  Output is an AXI-stream master that connects to gpif2_to_fifo32 rx_t* (tdata/tlast/tvalid/tready).
//  Requests come from the ctrl_tx decoder (trans type KEY_AND_STATUS, 3'b011) or an optional auto timer.
// PARAMETERS
//  STATUS_WORDS  6   32-bit status words per frame; frame = 2+STATUS_WORDS words (default 8 words = 32 bytes)
//  AUTO_PERIOD   0   clk cycles between automatic requests; 0 disables the timer
//  TRANS_TYPE    3'b011  type code placed in header word
// PORTS
//  clk          in   1   GPIF clock; the only clock
//  rst          in   1   synchronous, active-high reset
//  req          in   1   1-cycle pulse: send one frame
//  keys         in   10  GBA KEYINPUT, active-low, bit0=A .. bit9=L
//  status_data  in   32*STATUS_WORDS  word i = status_data[32*i+:32]
//  tx_tdata     out  32  frame word, byte 0 in [7:0]
//  tx_tlast     out  1   high on the final word of a frame only
//  tx_tvalid    out  1   word valid
//  tx_tready    in   1   sink accepts when tvalid&&tready
//  busy         out  1   high from frame start to last handshake
//  frame_done   out  1   1-cycle pulse on last-word handshake
//  drop_cnt     out  8   saturating count of coalesced (lost) requests
// BEHAVIOUR
//  Reset: tx_tvalid=0, tx_tlast=0, tx_tdata=0, busy=0, frame_done=0, drop_cnt=0, seq=0, pending=0, timer=0.
//  Frame: w0={seq[15:0],8'h00,5'b0,TRANS_TYPE}; w1={22'b0,keys}; w2..w(1+STATUS_WORDS)=status words 0..N-1.
//  States IDLE, SEND. All outputs registered.
//  IDLE: if pending or req (or timer hit): snapshot keys/status_data into frame buffer that cycle,
//    go SEND; tx_tvalid=1 with w0 on the next cycle (1-cycle req->tvalid latency). pending cleared.
//  SEND: word index advances only on tvalid&&tready; tdata/tlast held stable while tvalid&&!tready.
//    tlast asserted only with index = 1+STATUS_WORDS.
//  Last handshake: frame_done=1 next cycle; seq+1 (16-bit, wraps FFFF->0000).
//    If pending (or req/timer hit same cycle): re-snapshot and present w0 of next frame on the
//    following cycle with tvalid held high (back-to-back, no idle cycle); else tvalid=0, go IDLE.
//  Requests in SEND: first sets pending; further ones while pending=1 are dropped, drop_cnt+1
//    (saturates at 255). req and timer hit in the same cycle count as one request.
//  Snapshot isolation: key/status changes after snapshot never alter the frame in flight.
//  Timer: free-running 0..AUTO_PERIOD-1, hit on terminal count, independent of state; absent if 0.
//  busy = (state==SEND).
//  rst mid-frame: next cycle tvalid=0, partial frame abandoned (no tlast), seq and pending cleared.
// TESTING
//  1 req with keys=10'h3FF, status_data all 0, tready=1 -> 8 words, w0=32'h0000_0003, w1=32'h3FF, tlast only on w7, frame_done once
//  2 tready toggling 1/0 each cycle during frame -> tdata/tlast stable while stalled, 8 words in order, no duplicates
//  3 req, second req during word 3 -> second frame w0=32'h0001_0003 follows w7 with no tvalid gap
//  4 three reqs during one frame -> exactly 2 frames total, drop_cnt=1
//  5 force seq=16'hFFFF, send two frames -> w0 seq field FFFF then 0000
//  6 rst at word 4 -> tvalid=0 next cycle, no tlast emitted; new req sends w0 seq=0; AUTO_PERIOD=100 -> frame every 100 cycles

Source files
------------

// File: rtl/usb_status_tx.sv
// Key-and-status packetizer: snapshots GBA keys plus status words on request and
// streams a fixed 2+STATUS_WORDS word frame out of an AXI-stream master port.
module usb_status_tx #(
  parameter int         STATUS_WORDS = 6,
  parameter int         AUTO_PERIOD  = 0,
  parameter logic [2:0] TRANS_TYPE   = 3'b011
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic [9:0]                keys,
  input  logic [32*STATUS_WORDS-1:0] status_data,
  output logic [31:0]               tx_tdata,
  output logic                      tx_tlast,
  output logic                      tx_tvalid,
  input  logic                      tx_tready,
  output logic                      busy,
  output logic                      frame_done,
  output logic [7:0]                drop_cnt
);

  localparam int LAST = 1 + STATUS_WORDS;
  localparam int IW   = $clog2(LAST + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(LAST);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic [15:0]   seq;
  logic [15:0]   frame_seq;
  logic          pending;
  logic          timer_hit;
  logic          req_any;
  logic          hs;
  logic          last_hs;
  logic          start;
  logic [31:0]   frame_buf [1:LAST];

  generate
    if (AUTO_PERIOD > 0) begin : g_timer
      localparam int TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
      localparam logic [TW-1:0] TERM = TW'(AUTO_PERIOD - 1);
      logic [TW-1:0] timer;

      always_ff @(posedge clk) begin
        if (rst || timer == TERM) timer <= '0;
        else                      timer <= timer + 1'b1;
      end

      assign timer_hit = (timer == TERM);
    end else begin : g_no_timer
      assign timer_hit = 1'b0;
    end
  endgenerate

  assign req_any  = req | timer_hit;
  assign hs       = tx_tvalid & tx_tready;
  assign last_hs  = hs & tx_tlast;
  assign idx_next = idx + 1'b1;
  // A frame started on the closing handshake already carries the incremented sequence number.
  assign frame_seq = last_hs ? seq + 16'd1 : seq;
  assign busy     = (state == SEND);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (pending || req_any) begin
          start      = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (last_hs) begin
          if (pending || req_any) start = 1'b1;
          else                    state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Snapshot buffer; its contents only matter while a frame is in flight, so no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      frame_buf[1] <= {22'b0, keys};
      for (int i = 0; i < STATUS_WORDS; i++)
        frame_buf[i+2] <= status_data[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_tdata   <= '0;
      tx_tlast   <= 1'b0;
      tx_tvalid  <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
      seq        <= '0;
      pending    <= 1'b0;
      idx        <= '0;
    end else begin
      frame_done <= last_hs;
      if (last_hs) seq <= seq + 16'd1;

      if (start) begin
        tx_tdata  <= {frame_seq, 8'h00, 5'b0, TRANS_TYPE};
        tx_tvalid <= 1'b1;
        tx_tlast  <= 1'b0;
        idx       <= '0;
      end else if (last_hs) begin
        tx_tvalid <= 1'b0;
        tx_tlast  <= 1'b0;
      end else if (hs) begin
        idx      <= idx_next;
        tx_tdata <= frame_buf[idx_next];
        tx_tlast <= (idx_next == LAST_IDX);
      end

      // A request arriving with the restart is kept as the next pending frame.
      if (start) begin
        pending <= (state == SEND) && pending && req_any;
      end else if (state == SEND && req_any) begin
        if (!pending)               pending  <= 1'b1;
        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_usb_status_tx.sv
// Scoreboard bench for usb_status_tx: stimulus pushes expected frame words, a
// negedge monitor pops and compares them on every handshake.
module tb_usb_status_tx;

  localparam int SW = 6;
  localparam int NW = 2 + SW;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic [9:0]        keys;
  logic [32*SW-1:0]  status_data;
  logic [31:0]       tx_tdata;
  logic              tx_tlast;
  logic              tx_tvalid;
  logic              tx_tready;
  logic              busy;
  logic              frame_done;
  logic [7:0]        drop_cnt;

  logic [31:0]       a_tdata;
  logic              a_tlast;
  logic              a_tvalid;
  logic              a_busy;
  logic              a_frame_done;
  logic [7:0]        a_drop_cnt;

  int                errors = 0;
  int                checks = 0;
  int                cyc = 0;
  int                done_count = 0;
  int                last_done = 0;
  int                prev_done = 0;
  logic [32:0]       exp_q[$];
  logic              stall_prev = 1'b0;
  logic [32:0]       stall_word = '0;
  logic              tlast_hs_prev = 1'b0;
  int                a_frames = 0;
  int                a_last = 0;
  logic              a_have = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_status_tx #(.STATUS_WORDS(SW), .AUTO_PERIOD(0), .TRANS_TYPE(3'b011)) dut (
    .clk(clk), .rst(rst), .req(req), .keys(keys), .status_data(status_data),
    .tx_tdata(tx_tdata), .tx_tlast(tx_tlast), .tx_tvalid(tx_tvalid),
    .tx_tready(tx_tready), .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  usb_status_tx #(.STATUS_WORDS(SW), .AUTO_PERIOD(100), .TRANS_TYPE(3'b011)) dut_auto (
    .clk(clk), .rst(rst), .req(1'b0), .keys(10'h0F0), .status_data({(32*SW){1'b0}}),
    .tx_tdata(a_tdata), .tx_tlast(a_tlast), .tx_tvalid(a_tvalid),
    .tx_tready(1'b1), .busy(a_busy), .frame_done(a_frame_done), .drop_cnt(a_drop_cnt)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected words for one frame; n limits how many words are actually accepted.
  task automatic push_frame(input logic [15:0] s, input logic [9:0] k,
                            input logic [32*SW-1:0] st, input int n);
    logic [32:0] w [NW];
    w[0] = {1'b0, s, 8'h00, 8'h03};
    w[1] = {1'b0, 22'b0, k};
    for (int i = 0; i < SW; i++) w[i+2] = {(i == SW-1), st[32*i +: 32]};
    for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
  endtask

  task automatic apply_stimulus(input logic [15:0] s, input int n);
    push_frame(s, keys, status_data, n);
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_done(input int target, input bit toggle);
    for (int i = 0; i < 400 && done_count < target; i++) begin
      if (toggle) tx_tready = ~tx_tready;
      tick();
    end
    tx_tready = 1'b1;
    check_output("frame_count", done_count, target);
  endtask

  // Monitor: handshake scoreboard, stall stability and frame_done timing.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev    = 1'b0;
      tlast_hs_prev = 1'b0;
    end else begin
      if (tlast_hs_prev || frame_done)
        check_output("frame_done_timing", frame_done, tlast_hs_prev);
      if (frame_done) begin
        done_count++;
        prev_done = last_done;
        last_done = cyc;
      end
      if (stall_prev && tx_tvalid)
        check_output("stall_hold", {tx_tlast, tx_tdata}, stall_word);
      if (tx_tvalid && tx_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %0h, expected none", {tx_tlast, tx_tdata});
        end else begin
          check_output("word", {tx_tlast, tx_tdata}, exp_q.pop_front());
        end
      end
      stall_prev    = tx_tvalid && !tx_tready;
      stall_word    = {tx_tlast, tx_tdata};
      tlast_hs_prev = tx_tvalid && tx_tready && tx_tlast;
    end
  end

  // Auto-timer instance: consecutive frames must be exactly AUTO_PERIOD apart.
  always @(negedge clk) begin
    if (rst) begin
      a_have = 1'b0;
    end else if (a_frame_done) begin
      if (a_have) check_output("auto_period", cyc - a_last, 100);
      a_last = cyc;
      a_have = 1'b1;
      a_frames++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    req = 1'b0;
    tx_tready = 1'b1;
    keys = 10'h3FF;
    status_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_output("reset_state", {tx_tvalid, tx_tlast, tx_tdata, busy, frame_done, drop_cnt},
                 64'h0);

    $display("[TB] single frame");
    apply_stimulus(16'h0000, NW);
    check_output("req_latency", {tx_tvalid, busy, tx_tdata}, {2'b11, 32'h0000_0003});
    wait_done(1, 1'b0);
    repeat (2) tick();
    check_output("idle_after", {tx_tvalid, busy}, 2'b00);

    $display("[TB] tready toggling with input changes in flight");
    keys = 10'h155;
    for (int i = 0; i < SW; i++) status_data[32*i +: 32] = 32'hA5A5_0000 + i;
    apply_stimulus(16'h0001, NW);
    keys = 10'h000;
    status_data = ~status_data;
    wait_done(2, 1'b1);

    $display("[TB] back-to-back frames");
    keys = 10'h2AA;
    for (int i = 0; i < SW; i++) status_data[32*i +: 32] = 32'h1234_5600 + 17 * i;
    apply_stimulus(16'h0002, NW);
    push_frame(16'h0003, keys, status_data, NW);
    repeat (3) tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_done(4, 1'b0);
    check_output("b2b_gap", last_done - prev_done, 8);

    $display("[TB] request coalescing");
    apply_stimulus(16'h0004, NW);
    push_frame(16'h0005, keys, status_data, NW);
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_done(6, 1'b0);
    repeat (20) tick();
    check_output("no_extra_frame", done_count, 6);
    check_output("drop_cnt", drop_cnt, 8'd1);

    $display("[TB] sequence wrap");
    force dut.seq = 16'hFFFF;
    tick();
    release dut.seq;
    tick();
    apply_stimulus(16'hFFFF, NW);
    wait_done(7, 1'b0);
    apply_stimulus(16'h0000, NW);
    wait_done(8, 1'b0);

    $display("[TB] reset mid-frame");
    apply_stimulus(16'h0001, 4);
    repeat (4) tick();
    rst = 1'b1;
    tx_tready = 1'b0;
    tick();
    rst = 1'b0;
    tx_tready = 1'b1;
    check_output("reset_mid", {tx_tvalid, tx_tlast, busy, drop_cnt}, 11'h0);
    check_output("partial_words", exp_q.size(), 0);
    tick();
    apply_stimulus(16'h0000, NW);
    wait_done(9, 1'b0);

    repeat (250) tick();
    check_output("auto_frames", a_frames >= 3, 1);
    check_output("queue_drained", exp_q.size(), 0);
    check_output("final_frames", done_count, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
